ula_muldiv: RTL
===============

ULA_MULDIV -- requirements
Module: ula_muldiv

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits (legal values: even, 8 to 64).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only when busy=0.
REQ-005 funct3  input  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 op_a  input  WIDTH  first operand (multiplicand / dividend).
REQ-007 op_b  input  WIDTH  second operand (multiplier / divisor).
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  single-cycle pulse; result is valid in this cycle.
REQ-010 result  output  WIDTH  registered result, held until the next done.

Function
REQ-011 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-012 In IDLE or DONE with start=1, the block SHALL capture funct3, op_a and op_b at that edge.
REQ-012a After the capture edge the block SHALL enter CALC, or DONE on a fast path (REQ-019 and REQ-020), and clear the iteration counter.
REQ-013 start while busy=1 SHALL be ignored, and captured operands SHALL NOT change.
REQ-014 CALC SHALL perform exactly one iteration per cycle for WIDTH cycles.
REQ-014a After the WIDTH-th iteration the FSM SHALL go to DONE.
REQ-014b Normal latency: done SHALL be high in the cycle WIDTH+1 edges after the start edge.
REQ-015 DONE SHALL last exactly one cycle with done=1.
REQ-015a From DONE the FSM SHALL go to IDLE, or to CALC or DONE again if start=1 (back-to-back operations, no bubble).
REQ-016 busy SHALL be 1 exactly while in CALC.
REQ-016a result SHALL update only on the edge entering DONE.
REQ-017 Multiply SHALL be a shift-add on WIDTH-bit operand magnitudes into a 2*WIDTH-bit product, with the final sign applied in 2's complement.
REQ-017a Operand signedness for multiply: MULH = signed x signed; MULHSU = signed op_a x unsigned op_b; MULHU and MUL = unsigned magnitudes.
REQ-017b MUL SHALL return product[WIDTH-1:0]; the MULH variants SHALL return product[2*WIDTH-1:WIDTH].
REQ-018 Divide SHALL be restoring division, one quotient bit per cycle, on operand magnitudes.
REQ-018a DIV and REM SHALL treat operands as signed, with the quotient truncated toward zero and the remainder taking the sign of the dividend.
REQ-018b DIVU and REMU SHALL treat operands as unsigned.
REQ-019 Divide-by-zero (op_b=0, divide ops) SHALL skip CALC and go directly to DONE, with done high one edge later.
REQ-019a On divide-by-zero, DIV and DIVU SHALL return all ones; REM and REMU SHALL return op_a.
REQ-020 Signed overflow (DIV or REM, op_a = 1 followed by WIDTH-1 zeros, op_b = all ones) SHALL take the same fast path.
REQ-020a On signed overflow, DIV SHALL return op_a and REM SHALL return 0.
REQ-021 All internal arithmetic SHALL be WIDTH or 2*WIDTH bits wide with no loss of carry.
REQ-021a The magnitude of the most negative value SHALL be handled as an unsigned WIDTH-bit value.

Reset
REQ-022 With reset=1 at an edge, the FSM SHALL go to IDLE, and busy, done, result and the iteration counter SHALL all be 0.
REQ-022a Reset takes priority over start.
REQ-023 Reset mid-CALC SHALL abort the operation with no done pulse.
REQ-023a After reset is released, a new start SHALL behave normally.

Verification (WIDTH=32)
REQ-024 MUL, op_a=7, op_b=0xFFFFFFFD -> result 0xFFFFFFEB, done at start edge+33, busy high for 32 cycles.
REQ-025 MULH, op_a=op_b=0x80000000 -> result 0x40000000.
REQ-025a MULHU, op_a=op_b=0xFFFFFFFF -> result 0xFFFFFFFE.
REQ-026 DIV, op_a=0xFFFFFFF9, op_b=2 -> result 0xFFFFFFFD.
REQ-026a REM with the same operands -> result 0xFFFFFFFF.
REQ-027 DIVU 5/0 -> result 0xFFFFFFFF, done one edge after start, busy never high.
REQ-027a DIV 0x80000000/0xFFFFFFFF -> result 0x80000000.
REQ-027b REM with the same operands -> result 0.
REQ-028 Start a MUL, pulse start with different operands at cycle 10 -> ignored; the original result is returned.
REQ-028a Assert reset at cycle 20 -> busy=0, done never pulses, result=0.
REQ-029 Back-to-back: start held high in the DONE cycle -> the second operation enters CALC immediately, and its done arrives 33 cycles after the first done.

Source files
------------

// File: rtl/ula_muldiv.sv
// ula_muldiv -- iterative integer multiply/divide unit (RISC-V M-extension op set).
//
// Multiply is shift-add on operand magnitudes into a 2*WIDTH product; divide is
// restoring division on magnitudes. Both take WIDTH iterations, one per cycle,
// and the sign is applied to the final value in 2's complement. Divide-by-zero
// and signed overflow bypass the iteration and go straight to DONE.
//
// Ports:
//   clk     in   1      clock, rising edge
//   reset   in   1      synchronous, active-high
//   start   in   1      request pulse, honoured only when busy=0
//   funct3  in   3      000 MUL 001 MULH 010 MULHSU 011 MULHU
//                       100 DIV 101 DIVU 110 REM 111 REMU
//   op_a    in   WIDTH  multiplicand / dividend
//   op_b    in   WIDTH  multiplier / divisor
//   busy    out  1      high while iterating (CALC)
//   done    out  1      one-cycle pulse, result valid
//   result  out  WIDTH  registered result, held until the next done
module ula_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST     = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // Magnitude of a signed value; the most negative value maps to 2^(WIDTH-1)
  // as an unsigned WIDTH-bit number.
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign_w(input logic [WIDTH-1:0] v,
                                                    input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign_2w(input logic [2*WIDTH-1:0] v,
                                                       input logic n);
    return n ? -v : v;
  endfunction

  state_t             state, state_nxt;
  logic [2:0]         f3_q;
  logic               neg_q;
  logic [WIDTH-1:0]   opnd_q;   // multiplicand (mul) or divisor (div) magnitude
  logic [2*WIDTH-1:0] acc_q;    // mul: {hi, multiplier}  div: {remainder, quotient}
  logic [CW-1:0]      cnt_q;

  logic               capture;
  logic               a_sgn, b_sgn, sa, sb, neg_c, is_div, div_zero, ovf, fast;
  logic [WIDTH-1:0]   ma, mb, fast_res;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] div_acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   calc_res;

  assign capture = start && (state != CALC);

  // Operand decode at the capture edge: signedness, magnitudes, fast path.
  always_comb begin
    is_div   = funct3[2];
    a_sgn    = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    b_sgn    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    sa       = a_sgn & op_a[WIDTH-1];
    sb       = b_sgn & op_b[WIDTH-1];
    ma       = sa ? mag(op_a) : op_a;
    mb       = sb ? mag(op_b) : op_b;
    // Remainder follows the dividend's sign only.
    neg_c    = (funct3 == 3'b110) ? sa : (sa ^ sb);
    div_zero = is_div && (op_b == '0);
    ovf      = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
               (op_a == MOST_NEG) && (op_b == '1);
    fast     = div_zero || ovf;
    case (funct3)
      3'b100:  fast_res = div_zero ? '1 : op_a;
      3'b101:  fast_res = '1;
      3'b110:  fast_res = div_zero ? op_a : '0;
      default: fast_res = op_a;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_acc   = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_sub   = div_shift[WIDTH-1:0] - opnd_q;
    div_acc   = div_ge ? {div_sub, acc_q[WIDTH-2:0], 1'b1}
                       : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    acc_nxt   = f3_q[2] ? div_acc : mul_acc;
    prod      = apply_sign_2w(acc_nxt, neg_q);
    case (f3_q)
      3'b000:         calc_res = prod[WIDTH-1:0];
      3'b001, 3'b010,
      3'b011:         calc_res = prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101: calc_res = apply_sign_w(acc_nxt[WIDTH-1:0], neg_q);
      default:        calc_res = apply_sign_w(acc_nxt[2*WIDTH-1:WIDTH], neg_q);
    endcase
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) state_nxt = fast ? DONE : CALC;
        else       state_nxt = IDLE;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt_q == LAST) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt_q  <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        cnt_q <= '0;
        if (fast) result <= fast_res;
      end else if (state == CALC) begin
        cnt_q <= cnt_q + CW'(1);
        if (cnt_q == LAST) result <= calc_res;
      end
    end
  end

  // Datapath registers carry no reset; the FSM gates their use.
  always_ff @(posedge clk) begin
    if (capture) begin
      f3_q   <= funct3;
      neg_q  <= neg_c;
      opnd_q <= is_div ? mb : ma;
      acc_q  <= {{WIDTH{1'b0}}, (is_div ? ma : mb)};
    end else if (state == CALC) begin
      acc_q  <= acc_nxt;
    end
  end

endmodule
